// File: rtl/mat_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_loader
// Brief    : Assembles two NxN signed operand matrices from a row-per-beat
//            stream and strobes them into the pipelined matrix multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mat_row_loader #(
  parameter int W_IN = 8,
  parameter int N    = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cen,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_last,
  input  logic [N*W_IN-1:0]                  s_row,
  output logic [N-1:0][N-1:0][W_IN-1:0]      matrix_1,
  output logic [N-1:0][N-1:0][W_IN-1:0]      matrix_2,
  output logic                               valid_out,
  output logic                               frame_err
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST_A = CW'(N - 1);
  localparam logic [CW-1:0] C_LAST_B = CW'(2 * N - 1);
  localparam logic [CW-1:0] C_N      = CW'(N);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [RW-1:0]   w_row;
  logic            w_accept;
  logic            w_err;
  logic            w_wr_a;
  logic            w_wr_b;

  assign s_ready  = cen && rstn && (r_state != EMIT);
  assign w_accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_err        = 1'b0;
    w_wr_a       = 1'b0;
    w_wr_b       = 1'b0;
    w_row        = RW'(r_cnt);
    case (r_state)
      LOAD_A: begin
        if (w_accept) begin
          w_wr_a = 1'b1;
          if (s_last) begin
            w_err      = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == C_LAST_A) w_next_state = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        // Counter keeps running through 2N-1; operand B rows are offset by N.
        w_row = RW'(r_cnt - C_N);
        if (w_accept) begin
          w_wr_b = 1'b1;
          if (r_cnt == C_LAST_B && s_last) begin
            w_next_state = EMIT;
            w_cnt_next   = '0;
          end else if (r_cnt == C_LAST_B || s_last) begin
            w_err        = 1'b1;
            w_next_state = LOAD_A;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      EMIT: begin
        if (cen) begin
          w_next_state = LOAD_A;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_next_state = LOAD_A;
        w_cnt_next   = '0;
      end
    endcase
  end

  // valid_out follows EMIT occupancy, so a cen stall in EMIT holds it high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      matrix_1  <= '0;
      matrix_2  <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      valid_out <= (w_next_state == EMIT);
      frame_err <= w_err;
      if (w_wr_a) matrix_1[w_row] <= s_row;
      if (w_wr_b) matrix_2[w_row] <= s_row;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_row_loader
// Brief    : Randomized self-checking bench for mat_row_loader against a
//            queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_row_loader;

  localparam int W_IN = 8;
  localparam int N    = 8;
  localparam int ROWW = N * W_IN;
  localparam int MW   = N * N * W_IN;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          cen;
  logic                          s_valid;
  logic                          s_ready;
  logic                          s_last;
  logic [ROWW-1:0]               s_row;
  logic [N-1:0][N-1:0][W_IN-1:0] matrix_1;
  logic [N-1:0][N-1:0][W_IN-1:0] matrix_2;
  logic                          valid_out;
  logic                          frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: rows of the frame in progress, plus expected outputs.
  logic [ROWW-1:0] m_q[$];
  logic            m_emit;
  logic            m_err;
  logic [MW-1:0]   m_m1;
  logic [MW-1:0]   m_m2;
  int              pulses;

  mat_row_loader #(.W_IN(W_IN), .N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cen      (cen),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .s_row    (s_row),
    .matrix_1 (matrix_1),
    .matrix_2 (matrix_2),
    .valid_out(valid_out),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check ready, advance the model, check registered outputs.
  task automatic cycle(output bit acc);
    #1;
    chk("s_ready", MW'(s_ready), MW'(cen && rstn && !m_emit));
    acc = rstn && cen && s_valid && !m_emit;
    if (!rstn) begin
      m_q.delete();
      m_emit = 1'b0;
      m_err  = 1'b0;
      m_m1   = '0;
      m_m2   = '0;
    end else begin
      m_err = 1'b0;
      if (m_emit && cen) m_emit = 1'b0;
      if (acc) begin
        m_q.push_back(s_row);
        if (m_q.size() == 2 * N) begin
          if (s_last) begin
            m_emit = 1'b1;
            for (int r = 0; r < N; r++) begin
              m_m1[r*ROWW +: ROWW] = m_q[r];
              m_m2[r*ROWW +: ROWW] = m_q[N + r];
            end
          end else begin
            m_err = 1'b1;
          end
          m_q.delete();
        end else if (s_last) begin
          m_err = 1'b1;
          m_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", MW'(valid_out), MW'(m_emit));
    chk("frame_err", MW'(frame_err), MW'(m_err));
    if (valid_out) pulses++;
    if (m_emit || !rstn) begin
      chk("matrix_1", matrix_1, m_m1);
      chk("matrix_2", matrix_2, m_m2);
    end
    @(negedge clk);
  endtask

  function automatic logic [ROWW-1:0] make_row(input int kind, input int r);
    logic [ROWW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (kind == 0) begin
        if (r < N) v[j*W_IN +: W_IN] = W_IN'(r * N + j);
        else       v[j*W_IN +: W_IN] = (r - N == j) ? W_IN'(1) : W_IN'(0);
      end else begin
        v[j*W_IN +: W_IN] = W_IN'($urandom);
      end
    end
    if (kind != 0 && r == 0) begin
      v[0 +: W_IN]    = 8'h80;
      v[W_IN +: W_IN] = 8'hFF;
    end
    return v;
  endfunction

  task automatic beat(input logic [ROWW-1:0] row, input bit last, input int max_bubble);
    bit acc;
    int n;
    n = (max_bubble > 0) ? $urandom_range(max_bubble, 0) : 0;
    s_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle(acc);
    s_valid = 1'b1;
    s_row   = row;
    s_last  = last;
    for (int k = 0; k < 50; k++) begin
      cycle(acc);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", MW'(0), MW'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // err_mode: 0 clean, 1 s_last on beat 5 (frame stops there), 2 no s_last on beat 16.
  task automatic send_frame(input int kind, input int err_mode, input int max_bubble);
    int nbeats;
    nbeats = (err_mode == 1) ? 5 : 2 * N;
    for (int r = 0; r < nbeats; r++) begin
      beat(make_row(kind, r),
           (err_mode == 1) ? (r == 4) : (err_mode == 0 && r == 2 * N - 1),
           max_bubble);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    s_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle(acc);
  endtask

  initial begin
    bit acc;
    int p0;
    rstn    = 1'b0;
    cen     = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_row   = '1;
    m_q.delete();
    m_emit  = 1'b0;
    m_err   = 1'b0;
    m_m1    = '0;
    m_m2    = '0;
    pulses  = 0;
    @(negedge clk);

    // Reset held with valid asserted: nothing accepted, outputs zero.
    for (int k = 0; k < 3; k++) cycle(acc);
    s_valid = 1'b0;
    rstn    = 1'b1;
    idle(1);

    // Basic frame, back to back.
    p0 = pulses;
    send_frame(0, 0, 0);
    chk("m1[3][5]", MW'(matrix_1[3][5]), MW'(29));
    chk("m2[2][2]", MW'(matrix_2[2][2]), MW'(1));
    chk("m2[2][3]", MW'(matrix_2[2][3]), MW'(0));
    idle(2);
    chk("basic_pulses", MW'(pulses - p0), MW'(1));

    // Same frame with bubbles, then random frames with negative elements.
    p0 = pulses;
    send_frame(0, 0, 3);
    idle(2);
    chk("bubble_pulses", MW'(pulses - p0), MW'(1));
    for (int f = 0; f < 4; f++) begin
      send_frame(1, 0, 3);
      if (f == 0) begin
        chk("neg128", MW'(matrix_1[0][0]), MW'(8'h80));
        chk("neg1", MW'(matrix_1[0][1]), MW'(8'hFF));
      end
    end
    idle(2);

    // Early s_last, then a clean recovery frame.
    p0 = pulses;
    send_frame(0, 1, 1);
    idle(2);
    chk("early_last_pulses", MW'(pulses - p0), MW'(0));
    send_frame(1, 0, 2);
    idle(1);

    // Missing s_last on the final row.
    p0 = pulses;
    send_frame(1, 2, 1);
    idle(2);
    chk("missing_last_pulses", MW'(pulses - p0), MW'(0));

    // cen low mid-LOAD_B with valid held.
    for (int r = 0; r < 10; r++) beat(make_row(1, r), 1'b0, 0);
    s_valid = 1'b1;
    s_row   = make_row(1, 10);
    cen     = 1'b0;
    for (int k = 0; k < 3; k++) cycle(acc);
    cen = 1'b1;
    for (int r = 10; r < 2 * N; r++) beat(make_row(1, r), r == 2 * N - 1, 0);

    // cen low during EMIT: valid_out holds until an enabled edge.
    cen = 1'b0;
    idle(3);
    chk("emit_hold", MW'(valid_out), MW'(1));
    cen = 1'b1;
    idle(2);

    // Random mix of frames, bubbles and cen drops.
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < 2 * N; r++) begin
        if ($urandom_range(7, 0) == 0) begin
          cen = 1'b0;
          idle($urandom_range(2, 1));
          cen = 1'b1;
        end
        beat(make_row(1, r), r == 2 * N - 1, 2);
      end
    end
    idle(3);

    // Reset mid-frame discards accepted rows.
    for (int r = 0; r < 5; r++) beat(make_row(1, r), 1'b0, 0);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    p0 = pulses;
    send_frame(0, 0, 0);
    idle(1);
    chk("post_reset_pulses", MW'(pulses - p0), MW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
